// File: rtl/pythag_pkg.sv
// Shared types for the hypotenuse front end: coordinate width, segment entry
// and the path-tracking state.
package pythag_pkg;

    localparam int COORD_W = 8;

    typedef struct packed {
        logic [COORD_W-1:0] a;
        logic [COORD_W-1:0] b;
        logic               last;
    } seg_t;

    typedef enum logic {
        NO_PREV   = 1'b0,
        HAVE_PREV = 1'b1
    } path_state_e;

endpackage

// File: rtl/point_delta_gen_if.sv
// Point-in / segment-out handshake bundle for point_delta_gen.
interface point_delta_gen_if
    import pythag_pkg::*;
#(
    parameter int W = COORD_W
);
    logic         pt_valid;
    logic         pt_ready;
    logic [W-1:0] pt_x;
    logic [W-1:0] pt_y;
    logic         pt_last;
    logic         d_valid;
    logic         d_ready;
    logic [W-1:0] d_a;
    logic [W-1:0] d_b;
    logic         d_last;
    logic [7:0]   seg_count;

    modport slave (
        input  pt_valid, pt_x, pt_y, pt_last, d_ready,
        output pt_ready, d_valid, d_a, d_b, d_last, seg_count
    );

    modport master (
        output pt_valid, pt_x, pt_y, pt_last, d_ready,
        input  pt_ready, d_valid, d_a, d_b, d_last, seg_count
    );
endinterface

// File: rtl/delta_fifo.sv
// Small register-based FIFO; the head entry is visible combinationally so a
// push into an empty FIFO shows up right after the writing edge.
module delta_fifo
    import pythag_pkg::*;
#(
    parameter type T     = seg_t,
    parameter int  DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  T                         din_i,
    input  logic                     pop_i,
    output T                         dout_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_q, wr_d;
    logic [AW-1:0]  rd_q, rd_d;
    logic [AW:0]    count_q, count_d;
    logic           full;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full;
    assign pop_ok  = pop_i && !empty_o;
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_ok) begin
            wr_d = wr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_d = rd_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Entries are cleared on reset so the head reads as zero until written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_ok) begin
            mem_q[wr_q] <= din_i;
        end
    end

endmodule

// File: rtl/point_delta_gen.sv
// Turns a stream of path points into per-segment |dx|,|dy| entries, buffered
// in a small FIFO that feeds the hypotenuse stage.
module point_delta_gen
    import pythag_pkg::*;
#(
    parameter int W     = COORD_W,
    parameter int DEPTH = 2
) (
    input logic              clk,
    input logic              rst,
    point_delta_gen_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         last;
    } seg_w_t;

    path_state_e  state_q, state_d;
    logic [W-1:0] prev_x_q, prev_x_d;
    logic [W-1:0] prev_y_q, prev_y_d;
    logic [7:0]   seg_count_q, seg_count_d;
    logic         accept;
    logic         pop;
    logic         push;
    logic [W-1:0] abs_dx;
    logic [W-1:0] abs_dy;
    seg_w_t       push_seg;
    seg_w_t       head_seg;
    logic         fifo_empty;
    logic [AW:0]  fifo_count;

    assign bus.pt_ready  = (fifo_count < (AW+1)'(DEPTH));
    assign bus.d_valid   = !fifo_empty;
    assign bus.d_a       = head_seg.a;
    assign bus.d_b       = head_seg.b;
    assign bus.d_last    = head_seg.last;
    assign bus.seg_count = seg_count_q;

    assign accept = bus.pt_valid && bus.pt_ready;
    assign pop    = bus.d_valid && bus.d_ready;

    // Subtracting the smaller from the larger gives the magnitude of the
    // W+1-bit signed difference without ever needing the sign bit.
    assign abs_dx = (bus.pt_x >= prev_x_q) ? (bus.pt_x - prev_x_q) : (prev_x_q - bus.pt_x);
    assign abs_dy = (bus.pt_y >= prev_y_q) ? (bus.pt_y - prev_y_q) : (prev_y_q - bus.pt_y);

    assign push_seg = '{a: abs_dx, b: abs_dy, last: bus.pt_last};

    always_comb begin
        state_d     = state_q;
        prev_x_d    = prev_x_q;
        prev_y_d    = prev_y_q;
        seg_count_d = seg_count_q;
        push        = 1'b0;
        if (accept) begin
            prev_x_d = bus.pt_x;
            prev_y_d = bus.pt_y;
            case (state_q)
                NO_PREV: begin
                    // A lone last point is a one-point path: nothing to emit.
                    if (!bus.pt_last) begin
                        state_d     = HAVE_PREV;
                        seg_count_d = 8'd0;
                    end
                end
                HAVE_PREV: begin
                    push        = 1'b1;
                    seg_count_d = (seg_count_q == 8'd255) ? 8'd255 : seg_count_q + 8'd1;
                    if (bus.pt_last) begin
                        state_d = NO_PREV;
                    end
                end
                default: state_d = NO_PREV;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= NO_PREV;
            prev_x_q    <= '0;
            prev_y_q    <= '0;
            seg_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            prev_x_q    <= prev_x_d;
            prev_y_q    <= prev_y_d;
            seg_count_q <= seg_count_d;
        end
    end

    delta_fifo #(
        .T     (seg_w_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_seg),
        .pop_i   (pop),
        .dout_o  (head_seg),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule
